carry_gen_full_adder: RTL and testbench
=======================================

# carry_gen_full_adder

Registered 4-bit ALU slice built from four per-bit full-adder cells and a 4-bit carry-lookahead generator. Performs ADD, XOR, AND, OR and a 1-bit right shift with carry-in fill on two 4-bit operands. Exports the carry-out (group generate) and per-bit propagate so slices can be cascaded into wider ALUs. Sits in the datapath between the operand registers and the result bus.

## Interface

Parameters: none.

Ports:
- clk  input  1  sole clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands/controls valid this cycle
- d1  input  4  operand A
- d2  input  4  operand B; also the shift source
- carry_in  input  1  carry into bit 0; shift fill bit for RSHFT
- carry_disable  input  1  1 = suppress carries into the sum (turns ADD into XOR)
- cmd  input  2  00 = SUM, 01 = AND, 10 = OR, 11 = RSHFT
- b_inv  input  1  invert d2 before use (present only with CARRY_GEN_B_INV_EN)
- out_valid  output  1  res/carry_out/propagate valid
- res  output  4  result
- carry_out  output  1  carry out of bit 3 (group generate)
- propagate  output  4  per-bit propagate, d1[i] ^ b[i]

## Operation

- Effective B: b = b_inv ? ~d2 : d2 (b = d2 when the macro is off).
- Per bit i, full-adder cell:
  - g[i] = d1[i] & b[i]
  - p[i] = d1[i] ^ b[i]
  - ci = carry[i] & ~carry_disable
- Per-bit result by cmd:
  - SUM: p[i] ^ ci
  - AND: g[i]
  - OR: d1[i] | b[i]
  - RSHFT: s[i+1], with s = {carry_in, b}
- Carry lookahead, fully parallel (no ripple chain):
  - carry[0] = carry_in
  - carry[i+1] = g[i] | (p[i] & carry[i]), expanded as sum of products
  - carry_out = carry[4]
- Derived operations:
  - ADD = SUM with carry_disable = 0, giving res = (d1 + b + carry_in) mod 16, carry_out = the 5th bit.
  - XOR = SUM with carry_disable = 1, carry_in = 0, giving res = d1 ^ b.
- carry_out and propagate are computed for every cmd and are meaningful only for SUM.
- RSHFT: res = {carry_in, b[3:1]}; b[0] is discarded.

## Timing

- Single-stage pipeline, latency 1 cycle: inputs sampled on the rising edge where in_valid = 1; res, carry_out, propagate and out_valid update on that edge.
- in_valid = 0 at an edge: out_valid = 0 next cycle; res, carry_out and propagate hold their previous values.
- Back-to-back operations: one result per cycle, no stalls.
- Reset (rst_n low, asynchronous): res = 0, carry_out = 0, propagate = 0, out_valid = 0 immediately. Any operation in flight is dropped.
- First capture after reset: the first rising edge with rst_n high.
- The combinational path from inputs through lookahead to the register must close in one cycle; it has no internal ripple depth beyond 2 logic levels per carry.

## Configuration

- CARRY_GEN_B_INV_EN defined: b_inv port exists; b = b_inv ? ~d2 : d2. Subtraction is ADD with b_inv = 1, carry_in = 1, where carry_out = 1 means no borrow.
- Not defined: no b_inv port; b = d2 always.

## Test plan

- Reset: assert rst_n = 0 mid-operation -> res = 0, carry_out = 0, out_valid = 0 immediately. Release, then d1 = 3, d2 = 4, SUM -> next cycle res = 7, out_valid = 1.
- ADD exhaustive: all d1, d2 in 0..15 with carry_in = 0 -> res = (d1 + d2) & 15, carry_out = (d1 + d2 > 15). Spot check: 9 + 8 -> res = 1, carry_out = 1, propagate = 0001.
- XOR/AND/OR: d1 = 1100, d2 = 1010 -> res = 0110 (SUM, carry_disable = 1), 1000 (AND), 1110 (OR).
- RSHFT: d2 = 1011, carry_in = 0 -> res = 0101. Same with carry_in = 1 -> res = 1101.
- Valid gating: in_valid = 0 for one cycle between two ADDs -> out_valid pattern 1, 0, 1; res holds during the gap.
- CARRY_GEN_B_INV_EN: d1 = 7, d2 = 3, b_inv = 1, carry_in = 1, SUM -> res = 4, carry_out = 1. d1 = 3, d2 = 7 -> res = 12, carry_out = 0.

Source files
------------

// File: rtl/carry_gen_full_adder.sv
// carry_gen_full_adder: registered 4-bit ALU slice (ADD/XOR, AND, OR, RSHFT)
// built from four full-adder cells and a parallel carry-lookahead generator.
// Optional feature macro: CARRY_GEN_B_INV_EN adds the b_inv port so that
// operand B can be inverted (subtraction = ADD with b_inv = 1, carry_in = 1).

// One full-adder cell: local generate, propagate and sum for a single bit
module carry_gen_fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic g,
   output logic p,
   output logic s
);
   assign g = a & b;
   assign p = a ^ b;
   assign s = p ^ ci;
endmodule

// 4-bit carry-lookahead generator, every carry a flat sum of products
module carry_gen_cla4 (
   input  logic [3:0] g,
   input  logic [3:0] p,
   input  logic       c0,
   output logic [4:0] carry
);
   assign carry[0] = c0;
   assign carry[1] = g[0]
                   | (p[0] & c0);
   assign carry[2] = g[1]
                   | (p[1] & g[0])
                   | (p[1] & p[0] & c0);
   assign carry[3] = g[2]
                   | (p[2] & g[1])
                   | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & c0);
   assign carry[4] = g[3]
                   | (p[3] & g[2])
                   | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & c0);
endmodule

module carry_gen_full_adder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic       carry_in,
   input  logic       carry_disable,
   input  logic [1:0] cmd,
`ifdef CARRY_GEN_B_INV_EN
   input  logic       b_inv,
`endif
   output logic       out_valid,
   output logic [3:0] res,
   output logic       carry_out,
   output logic [3:0] propagate
);

   localparam logic [1:0] CMD_SUM   = 2'b00;
   localparam logic [1:0] CMD_AND   = 2'b01;
   localparam logic [1:0] CMD_OR    = 2'b10;
   localparam logic [1:0] CMD_RSHFT = 2'b11;

   logic [3:0] b;
   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] ci;
   logic [3:0] sum;
   logic [4:0] carry;
   logic [3:0] res_next;

`ifdef CARRY_GEN_B_INV_EN
   assign b = b_inv ? ~d2 : d2;
`else
   assign b = d2;
`endif

   carry_gen_cla4 u_cla (
      .g     (g),
      .p     (p),
      .c0    (carry_in),
      .carry (carry)
   );

   // carry_disable only masks the carries entering the sum bits; the
   // lookahead itself (and so carry_out) is always computed
   assign ci = carry[3:0] & {4{~carry_disable}};

   for (genvar i = 0; i < 4; i++) begin : g_bit
      carry_gen_fa_cell u_fa (
         .a  (d1[i]),
         .b  (b[i]),
         .ci (ci[i]),
         .g  (g[i]),
         .p  (p[i]),
         .s  (sum[i])
      );
   end

   // Select the per-bit result according to the command
   always_comb begin
      res_next = sum;
      case (cmd)
         CMD_SUM:   res_next = sum;
         CMD_AND:   res_next = g;
         CMD_OR:    res_next = d1 | b;
         CMD_RSHFT: res_next = {carry_in, b[3:1]};
         default:   res_next = sum;
      endcase
   end

   // Output register: capture on valid cycles, hold data otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         res       <= 4'd0;
         carry_out <= 1'b0;
         propagate <= 4'd0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            res       <= res_next;
            carry_out <= carry[4];
            propagate <= p;
         end
      end
   end

endmodule

// File: tb/tb_carry_gen_full_adder.sv
// Self-checking bench for carry_gen_full_adder with a behavioural model.
// Optional feature macro: CARRY_GEN_B_INV_EN enables the b_inv checks.
module tb_carry_gen_full_adder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] d1;
   logic [3:0] d2;
   logic       carry_in;
   logic       carry_disable;
   logic [1:0] cmd;
`ifdef CARRY_GEN_B_INV_EN
   logic       b_inv;
`endif
   logic       out_valid;
   logic [3:0] res;
   logic       carry_out;
   logic [3:0] propagate;

   int total;
   int bad;

   // Expected registered state
   logic       exp_valid;
   logic [3:0] exp_res;
   logic       exp_co;
   logic [3:0] exp_prop;

   carry_gen_full_adder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .d1            (d1),
      .d2            (d2),
      .carry_in      (carry_in),
      .carry_disable (carry_disable),
      .cmd           (cmd),
`ifdef CARRY_GEN_B_INV_EN
      .b_inv         (b_inv),
`endif
      .out_valid     (out_valid),
      .res           (res),
      .carry_out     (carry_out),
      .propagate     (propagate)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic reference: returns {carry_out, propagate, res}
   function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] d,
                                        input logic cin, input logic cdis,
                                        input logic [1:0] op, input logic inv);
      int bv;
      int total_sum;
      int r;
      bv = inv ? (15 - int'(d)) : int'(d);
      total_sum = int'(a) + bv + int'(cin);
      case (op)
         2'd0:    r = cdis ? (int'(a) ^ bv) : (total_sum % 16);
         2'd1:    r = int'(a) & bv;
         2'd2:    r = int'(a) | bv;
         default: r = (int'(cin) * 16 + bv) / 2;
      endcase
      model = {(total_sum >= 16), 4'(int'(a) ^ bv), 4'(r)};
   endfunction

   // Drive one cycle of inputs, advance past the edge and update expectations
   task automatic apply_op(input logic v, input logic [3:0] a, input logic [3:0] d,
                           input logic cin, input logic cdis, input logic [1:0] op,
                           input logic inv);
      logic [8:0] m;
      in_valid = v; d1 = a; d2 = d; carry_in = cin; carry_disable = cdis; cmd = op;
`ifdef CARRY_GEN_B_INV_EN
      b_inv = inv;
`endif
      m = model(a, d, cin, cdis, op, inv);
      @(posedge clk);
      #1;
      exp_valid = v;
      if (v) begin
         exp_res  = m[3:0];
         exp_prop = m[7:4];
         exp_co   = m[8];
      end
   endtask

   task automatic test_reset();
      apply_op(1'b1, 4'd9, 4'd8, 1'b0, 1'b0, 2'd0, 1'b0);
      in_valid = 1'b1; d1 = 4'd15; d2 = 4'd15;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || res !== 4'd0 || carry_out !== 1'b0 || propagate !== 4'd0) begin
         bad++;
         $display("[TB] FAIL reset_async: valid=%b res=%h co=%b prop=%h required 0 0 0 0",
                  out_valid, res, carry_out, propagate);
      end
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || res !== 4'd0) begin
         bad++;
         $display("[TB] FAIL reset_hold: valid=%b res=%h required 0 0", out_valid, res);
      end
      #2;
      rst_n = 1'b1;
      exp_valid = 1'b0; exp_res = 4'd0; exp_co = 1'b0; exp_prop = 4'd0;
      apply_op(1'b1, 4'd3, 4'd4, 1'b0, 1'b0, 2'd0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || res !== 4'd7 || carry_out !== 1'b0 || propagate !== 4'd7) begin
         bad++;
         $display("[TB] FAIL reset_first_op: valid=%b res=%h co=%b prop=%h required 1 7 0 7",
                  out_valid, res, carry_out, propagate);
      end
   endtask

   task automatic test_add_exhaustive();
      int s;
      for (int a = 0; a < 16; a++) begin
         for (int d = 0; d < 16; d++) begin
            apply_op(1'b1, 4'(a), 4'(d), 1'b0, 1'b0, 2'd0, 1'b0);
            s = a + d;
            total++;
            if (res !== 4'(s % 16) || carry_out !== (s > 15) || out_valid !== 1'b1) begin
               bad++;
               $display("[TB] FAIL add_%0d_%0d: res=%h co=%b valid=%b required %h %b 1",
                        a, d, res, carry_out, out_valid, 4'(s % 16), (s > 15));
            end
         end
      end
      apply_op(1'b1, 4'd9, 4'd8, 1'b0, 1'b0, 2'd0, 1'b0);
      total++;
      if (res !== 4'd1 || carry_out !== 1'b1 || propagate !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL add_9_8_spot: res=%h co=%b prop=%b required 1 1 0001",
                  res, carry_out, propagate);
      end
   endtask

   task automatic test_logic_ops();
      apply_op(1'b1, 4'b1100, 4'b1010, 1'b0, 1'b1, 2'd0, 1'b0);
      total++;
      if (res !== 4'b0110) begin
         bad++;
         $display("[TB] FAIL xor: res=%b required 0110", res);
      end
      apply_op(1'b1, 4'b1100, 4'b1010, 1'b0, 1'b0, 2'd1, 1'b0);
      total++;
      if (res !== 4'b1000) begin
         bad++;
         $display("[TB] FAIL and: res=%b required 1000", res);
      end
      apply_op(1'b1, 4'b1100, 4'b1010, 1'b0, 1'b0, 2'd2, 1'b0);
      total++;
      if (res !== 4'b1110) begin
         bad++;
         $display("[TB] FAIL or: res=%b required 1110", res);
      end
   endtask

   task automatic test_rshft();
      apply_op(1'b1, 4'd0, 4'b1011, 1'b0, 1'b0, 2'd3, 1'b0);
      total++;
      if (res !== 4'b0101) begin
         bad++;
         $display("[TB] FAIL rshft_cin0: res=%b required 0101", res);
      end
      apply_op(1'b1, 4'd0, 4'b1011, 1'b1, 1'b0, 2'd3, 1'b0);
      total++;
      if (res !== 4'b1101) begin
         bad++;
         $display("[TB] FAIL rshft_cin1: res=%b required 1101", res);
      end
   endtask

   task automatic test_valid_gating();
      apply_op(1'b1, 4'd2, 4'd5, 1'b0, 1'b0, 2'd0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || res !== 4'd7) begin
         bad++;
         $display("[TB] FAIL gate_first: valid=%b res=%h required 1 7", out_valid, res);
      end
      apply_op(1'b0, 4'd15, 4'd15, 1'b1, 1'b0, 2'd0, 1'b0);
      total++;
      if (out_valid !== 1'b0 || res !== 4'd7 || carry_out !== 1'b0 || propagate !== 4'd7) begin
         bad++;
         $display("[TB] FAIL gate_gap: valid=%b res=%h co=%b prop=%h required 0 7 0 7",
                  out_valid, res, carry_out, propagate);
      end
      apply_op(1'b1, 4'd6, 4'd6, 1'b1, 1'b0, 2'd0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || res !== 4'd13) begin
         bad++;
         $display("[TB] FAIL gate_second: valid=%b res=%h required 1 d", out_valid, res);
      end
   endtask

   task automatic test_random();
      logic inv;
      for (int i = 0; i < 400; i++) begin
         inv = 1'b0;
`ifdef CARRY_GEN_B_INV_EN
         inv = 1'($urandom_range(0, 1));
`endif
         apply_op(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 2'($urandom), inv);
         total++;
         if (out_valid !== exp_valid || res !== exp_res || carry_out !== exp_co ||
             propagate !== exp_prop) begin
            bad++;
            $display("[TB] FAIL random_%0d: valid=%b res=%h co=%b prop=%h required %b %h %b %h",
                     i, out_valid, res, carry_out, propagate, exp_valid, exp_res, exp_co, exp_prop);
         end
      end
   endtask

`ifdef CARRY_GEN_B_INV_EN
   task automatic test_b_inv();
      apply_op(1'b1, 4'd7, 4'd3, 1'b1, 1'b0, 2'd0, 1'b1);
      total++;
      if (res !== 4'd4 || carry_out !== 1'b1) begin
         bad++;
         $display("[TB] FAIL sub_7_3: res=%h co=%b required 4 1", res, carry_out);
      end
      apply_op(1'b1, 4'd3, 4'd7, 1'b1, 1'b0, 2'd0, 1'b1);
      total++;
      if (res !== 4'd12 || carry_out !== 1'b0) begin
         bad++;
         $display("[TB] FAIL sub_3_7: res=%h co=%b required c 0", res, carry_out);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; d1 = 4'd0; d2 = 4'd0; carry_in = 1'b0;
      carry_disable = 1'b0; cmd = 2'd0;
`ifdef CARRY_GEN_B_INV_EN
      b_inv = 1'b0;
`endif
      exp_valid = 1'b0; exp_res = 4'd0; exp_co = 1'b0; exp_prop = 4'd0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      test_reset();
      test_add_exhaustive();
      test_logic_ops();
      test_rshft();
      test_valid_gating();
`ifdef CARRY_GEN_B_INV_EN
      test_b_inv();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
